imm_gen_queue: RTL and testbench
================================

# imm_gen_queue

Parametrised, registered immediate generator for the decode stage. It takes a full 32-bit instruction and an immediate-format select under a valid/ready handshake, and extracts and sign-extends the immediate to XLEN. Results queue in order, with tags, in a DEPTH-entry FIFO that feeds execute. Compared with a purely combinational extractor, it adds back-pressure buffering, flush, CSR-zimm/shamt formats, XLEN=64 support and illegal-format flagging.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TAG_W, 5, width of the opaque tag carried with each entry.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous; empties the queue.
- InValid  in  1  producer presents Inst/ImmSrc/InTag.
- InReady  out  1  queue can accept an entry.
- Inst  in  32  full instruction word.
- ImmSrc  in  3  format select.
- InTag  in  TAG_W  passed through unchanged.
- OutValid  out  1  head entry is valid.
- OutReady  in  1  consumer accepts the head entry.
- ImmExt  out  XLEN  head immediate.
- OutTag  out  TAG_W  head tag.
- Illegal  out  1  head entry had an unsupported ImmSrc.

## Operation
ImmSrc encodings; sext means sign-extend to XLEN, zext means zero-extend:
- 000 I: sext(Inst[31:20]).
- 001 S: sext({Inst[31:25],Inst[11:7]}).
- 101 B: sext({Inst[31],Inst[7],Inst[30:25],Inst[11:8],1'b0}).
- 010 U: sext({Inst[31:12],12'b0}).
- 110 J: sext({Inst[31],Inst[19:12],Inst[20],Inst[30:21],1'b0}).
- 011 Z: zext(Inst[19:15]) (CSR zimm).
- 100 SH: zext(Inst[25:20]) when XLEN=64; zext(Inst[24:20]) when XLEN=32.
- 111: ImmExt=0, Illegal=1. All other encodings give Illegal=0.

Queue behaviour:
- Extraction is combinational on the input side. The result, tag and Illegal bit are written into the FIFO on a push.
- Push = InValid && InReady. Pop = OutValid && OutReady.
- InReady = (count < DEPTH). It is driven from registered count only, with no same-cycle pop-through when full.
- OutValid = (count != 0).
- ImmExt, OutTag and Illegal show the head entry. They are forced to 0 when the queue is empty.
- Push and pop in the same cycle (count between 1 and DEPTH-1) leave count unchanged. Both pointers advance and wrap modulo DEPTH.
- Entries leave strictly in FIFO order.
- Flush has priority over push and pop: count and pointers go to 0, and any same-cycle push is dropped.
- Holding rule: while OutValid=1 and OutReady=0, the head outputs stay stable.
- Producer obligation: while InValid=1 and InReady=0, the producer holds its inputs stable. The bench checks this; the block does not.

## Timing
- Reset (asynchronous assert, released synchronously by the environment): count=0, pointers=0, InReady=1, OutValid=0, ImmExt=0, OutTag=0, Illegal=0. Reset mid-stream discards all entries immediately.
- Latency: an entry pushed at edge N gives OutValid=1 with its data after edge N, i.e. visible in cycle N+1. There is no input-to-output combinational path.
- Throughput: one entry per cycle while the consumer accepts.
- Full: after DEPTH pushes with no pops, InReady=0 in the next cycle. A pop at edge M gives InReady=1 after M.
- Flush at edge F: OutValid=0 and InReady=1 after F.

## Structure
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_src_e with values IMM_I, IMM_S, IMM_U, IMM_Z, IMM_SH, IMM_B, IMM_J, IMM_ILL;
  - localparam XLEN_DEFAULT=32;
  - the struct imm_entry_t {imm, tag, illegal}, parametrised through the top level.
- Sub-module imm_decode: purely combinational extraction, parametrised by XLEN. Outputs imm and illegal.
- Top level: FIFO storage, pointers, count register and handshake logic.

## Test plan
- Push I-type Inst=32'hFFF00093, ImmSrc=000, InTag=3 -> next cycle OutValid=1, ImmExt=32'hFFFFFFFF, OutTag=3, Illegal=0.
- Push B-type 32'hFE000EE3 (ImmSrc=101), then U-type 32'h123450B7 (ImmSrc=010), then Z-type 32'h000F5073 (ImmSrc=011) back to back, with OutReady=1 -> ImmExt sequence FFFFFFFC, 12345000, 0000001E, one per cycle in order.
- Hold OutReady=0 and push 5 entries -> InReady=0 after the 4th accept, the 5th is held. Raise OutReady -> all 5 entries emerge in order; head outputs stay stable while stalled.
- Fill with 3 entries, then assert Flush together with InValid=1 -> OutValid=0 next cycle and the flushed push never appears.
- ImmSrc=111 -> ImmExt=0, Illegal=1. XLEN=64 build: J-type 32'hFFDFF06F -> ImmExt=64'hFFFFFFFFFFFFFFFC; SH 32'h03F01013 -> 0x3F.
- Assert rst asynchronously mid-stream with 2 entries queued -> all outputs 0 and InReady=1 immediately, with no entry emitted afterwards.

Source files
------------

// File: rtl/imm_gen_queue_pkg.sv
// imm_pkg: shared definitions for the registered immediate generator.
//   imm_src_e    - 3-bit immediate-format select as presented on ImmSrc.
//   XLEN_DEFAULT - default datapath width for imm_decode and imm_gen_queue.
// The queue entry struct depends on the XLEN/TAG_W parameters of the
// instantiating module, so it is declared inside imm_gen_queue.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_U   = 3'b010,
    IMM_Z   = 3'b011,
    IMM_SH  = 3'b100,
    IMM_B   = 3'b101,
    IMM_J   = 3'b110,
    IMM_ILL = 3'b111
  } imm_src_e;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/imm_gen_queue_decode.sv
// imm_decode: purely combinational immediate extraction.
// Ports:
//   inst    in  [31:0]      full instruction word
//   imm_src in  [2:0]       format select (imm_src_e)
//   imm     out [XLEN-1:0]  extracted immediate, sign- or zero-extended
//   illegal out             imm_src selects no supported format
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // raw holds the immediate already extended to 32 bits; sext says whether
  // the remaining XLEN-32 bits (XLEN=64) replicate bit 31 or are zero.
  logic [31:0] raw;
  logic        sext;

  always_comb begin
    raw     = '0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I: begin
        raw  = {{20{inst[31]}}, inst[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {inst[31:12], 12'b0};
        sext = 1'b1;
      end
      IMM_J: begin
        raw  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_Z: begin
        raw = {27'b0, inst[19:15]};
      end
      IMM_SH: begin
        // RV64 shift amounts use six bits, RV32 only five.
        raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      end
      IMM_ILL: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

endmodule

// File: rtl/imm_gen_queue.sv
// imm_gen_queue: registered immediate generator feeding execute through a
// DEPTH-entry in-order FIFO with tags, flush and illegal-format flagging.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   Flush              synchronous queue flush (beats push and pop)
//   InValid / InReady  producer handshake for Inst, ImmSrc, InTag
//   Inst, ImmSrc       instruction word and format select
//   InTag              opaque tag carried with the entry
//   OutValid/OutReady  consumer handshake for the head entry
//   ImmExt, OutTag     head immediate and tag (0 when empty)
//   Illegal            head entry had an unsupported ImmSrc (0 when empty)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. InReady depends only on the registered count (no pop-through
// when full) and OutValid only on the registered count, so there is no
// combinational path from any input to any output. A producer that sees
// InReady low must keep its inputs stable; the consumer may drop OutReady
// at any time and the head outputs then stay stable.
module imm_gen_queue
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Inst,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] OutTag,
  output logic             Illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } imm_entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  imm_entry_t      push_entry;
  imm_entry_t      head_entry;
  imm_entry_t      mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, mem_we;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (Inst),
    .imm_src (ImmSrc),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign push_entry = '{imm: dec_imm, tag: InTag, illegal: dec_illegal};

  assign InReady  = (count_q != CNT_W'(DEPTH));
  assign OutValid = (count_q != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;
  assign mem_we   = push && !Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while count says
  // they are valid, and the outputs are gated to zero when empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign ImmExt     = OutValid ? head_entry.imm     : '0;
  assign OutTag     = OutValid ? head_entry.tag     : '0;
  assign Illegal    = OutValid ? head_entry.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_queue.sv
module tb_imm_gen_queue;

  localparam int DEPTH = 4;
  localparam int TW    = 5;
  localparam int W32   = 32 + TW + 1;
  localparam int W64   = 64 + TW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          Flush = 1'b0;
  logic          InValid = 1'b0;
  logic [31:0]   Inst = '0;
  logic [2:0]    ImmSrc = '0;
  logic [TW-1:0] InTag = '0;
  logic          OutReady = 1'b0;

  logic          in_ready32, out_valid32, illegal32;
  logic [31:0]   imm32;
  logic [TW-1:0] tag32;
  logic          in_ready64, out_valid64, illegal64;
  logic [63:0]   imm64;
  logic [TW-1:0] tag64;

  imm_gen_queue #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TW)) dut32 (
    .clk(clk), .rst(rst), .Flush(Flush), .InValid(InValid), .InReady(in_ready32),
    .Inst(Inst), .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(out_valid32),
    .OutReady(OutReady), .ImmExt(imm32), .OutTag(tag32), .Illegal(illegal32)
  );

  imm_gen_queue #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TW)) dut64 (
    .clk(clk), .rst(rst), .Flush(Flush), .InValid(InValid), .InReady(in_ready64),
    .Inst(Inst), .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(out_valid64),
    .OutReady(OutReady), .ImmExt(imm64), .OutTag(tag64), .Illegal(illegal64)
  );

  // ---------------- scoreboard ----------------
  logic [W32-1:0] exp32_q[$];
  logic [W64-1:0] exp64_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: field value from the format's bit positions, then
  // two's-complement interpretation of an n-bit field by arithmetic.
  function automatic longint sext_n(input longint raw, input int n);
    longint lim;
    lim = longint'(1) << (n - 1);
    return (raw >= lim) ? raw - (lim * 2) : raw;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] src,
                                          input bit is64, output logic ill);
    longint v;
    ill = 1'b0;
    v   = 0;
    case (src)
      3'd0: v = sext_n(longint'(inst[31:20]), 12);
      3'd1: v = sext_n(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      3'd5: v = sext_n(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                       longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      3'd2: v = sext_n(longint'(inst[31:12]) * 4096, 32);
      3'd6: v = sext_n(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                       longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      3'd3: v = longint'(inst[19:15]);
      3'd4: v = is64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
      default: begin v = 0; ill = 1'b1; end
    endcase
    if (!is64) v = v & 64'h0000_0000_FFFF_FFFF;
    return 64'(v);
  endfunction

  // ---------------- monitor ----------------
  logic           mon_en = 1'b0;
  logic           stalled = 1'b0;
  logic [W32-1:0] cur32, prev32;
  logic [W64-1:0] cur64, prev64;
  int             n_ent;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_ent = exp32_q.size();
      cur32 = {illegal32, tag32, imm32};
      cur64 = {illegal64, tag64, imm64};
      chk("in_ready", {in_ready32, in_ready64}, {2{n_ent < DEPTH}});
      chk("out_valid", {out_valid32, out_valid64}, {2{n_ent != 0}});
      if (n_ent == 0) begin
        chk("empty_zero32", cur32, '0);
        chk("empty_zero64", cur64, '0);
      end else begin
        chk("head32", cur32, exp32_q[0]);
        chk("head64", cur64, exp64_q[0]);
      end
      if (stalled) begin
        chk("hold32", cur32, prev32);
        chk("hold64", cur64, prev64);
      end
      if (Flush) begin
        exp32_q.delete();
        exp64_q.delete();
      end else if (n_ent != 0 && OutReady) begin
        void'(exp32_q.pop_front());
        void'(exp64_q.pop_front());
      end
      stalled = (n_ent != 0) && !OutReady && !Flush;
      prev32  = cur32;
      prev64  = cur64;
    end else begin
      stalled = 1'b0;
    end
  end

  // Randomised consumer readiness, enabled only during the random phase.
  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) OutReady = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_raw(input logic [31:0] inst, input logic [2:0] src, input logic [TW-1:0] tag,
                          input logic [W32-1:0] e32, input logic [W64-1:0] e64);
    logic acc;
    Inst    = inst;
    ImmSrc  = src;
    InTag   = tag;
    InValid = 1'b1;
    acc     = 1'b0;
    for (int c = 0; c < 500 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready32 && !Flush;
      // Producer obligation: inputs stable while waiting.
      if (!acc) chk("producer_hold", {Inst, ImmSrc, InTag}, {inst, src, tag});
      @(posedge clk);
    end
    chk("push_accept", acc, 1'b1);
    if (acc) begin
      exp32_q.push_back(e32);
      exp64_q.push_back(e64);
    end
    #1;
    InValid = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [2:0] src, input logic [TW-1:0] tag);
    logic [63:0] r32, r64;
    logic        ill;
    r32 = ref_imm(inst, src, 1'b0, ill);
    r64 = ref_imm(inst, src, 1'b1, ill);
    push_raw(inst, src, tag, {ill, tag, r32[31:0]}, {ill, tag, r64});
  endtask

  task automatic push_k(input logic [31:0] inst, input logic [2:0] src, input logic [TW-1:0] tag,
                        input logic [31:0] k32, input logic [63:0] k64, input logic ill);
    push_raw(inst, src, tag, {ill, tag, k32}, {ill, tag, k64});
  endtask

  task automatic do_flush();
    Flush   = 1'b1;
    InValid = 1'b1;
    Inst    = $urandom;
    ImmSrc  = 3'd0;
    InTag   = 5'd31;
    @(posedge clk);
    #1;
    Flush   = 1'b0;
    InValid = 1'b0;
    chk("flush_out_valid", out_valid32, 1'b0);
    chk("flush_in_ready", in_ready32, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out32", {in_ready32, out_valid32, imm32, tag32, illegal32}, {1'b1, 1'b0, 32'h0, 5'h0, 1'b0});
    chk("rst_out64", {in_ready64, out_valid64, imm64, tag64, illegal64}, {1'b1, 1'b0, 64'h0, 5'h0, 1'b0});
    exp32_q.delete();
    exp64_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state32", {in_ready32, out_valid32, imm32, tag32, illegal32}, {1'b1, 1'b0, 32'h0, 5'h0, 1'b0});
    chk("reset_state64", {in_ready64, out_valid64, imm64, tag64, illegal64}, {1'b1, 1'b0, 64'h0, 5'h0, 1'b0});
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Single I-type, then B/U/Z back to back with the consumer ready.
    OutReady = 1'b1;
    push_k(32'hFFF00093, 3'b000, 5'd3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    idle(2);
    push_k(32'hFE000EE3, 3'b101, 5'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_k(32'h123450B7, 3'b010, 5'd5, 32'h12345000, 64'h0000000012345000, 1'b0);
    push_k(32'h000F5073, 3'b011, 5'd6, 32'h0000001E, 64'h000000000000001E, 1'b0);
    push_k(32'h12345677, 3'b111, 5'd7, 32'h0, 64'h0, 1'b1);
    push_k(32'hFFDFF06F, 3'b110, 5'd8, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_k(32'h03F01013, 3'b100, 5'd9, 32'h0000001F, 64'h000000000000003F, 1'b0);
    idle(3);

    // Stall consumer, push 5: the 5th waits until OutReady rises.
    OutReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) push_one($urandom, 3'($urandom_range(0, 7)), 5'(i + 10));
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", in_ready32, 1'b0);
        @(posedge clk);
        #1;
        OutReady = 1'b1;
      end
    join
    idle(8);

    // Fill 3, flush together with a push.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) push_one($urandom, 3'($urandom_range(0, 7)), 5'(i + 20));
    do_flush();
    OutReady = 1'b1;
    idle(3);

    // Asynchronous reset with 2 entries queued.
    OutReady = 1'b0;
    for (int i = 0; i < 2; i++) push_one($urandom, 3'($urandom_range(0, 7)), 5'(i + 24));
    do_reset();
    OutReady = 1'b1;
    idle(4);

    // Random phase.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) do_flush();
      else push_one($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    OutReady = 1'b1;
    for (int c = 0; c < 100 && exp32_q.size() != 0; c++) idle(1);
    chk("drain_empty", 32'(exp32_q.size()), 32'd0);
    idle(2);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
